// File: rtl/issue_queue.sv
// Age-ordered, compacting issue queue: tracks per-register readiness, wakes entries
// from the writeback bus and presents the oldest fully-ready uop for issue.
package iq_pkg;
  localparam int UOP_TAG_W = 7;

  typedef struct packed {
    logic [15:0]          id;
    logic [UOP_TAG_W-1:0] rs1;
    logic                 rs1_valid;
    logic [UOP_TAG_W-1:0] rs2;
    logic                 rs2_valid;
    logic [UOP_TAG_W-1:0] rd;
    logic                 rd_valid;
  } uop_t;
endpackage

module issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PHY_RF_DEPTH = 128,
  localparam int TAG_W = $clog2(PHY_RF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  uop_t             uop_in,
  input  logic             uop_in_valid,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output uop_t             uop_out,
  output logic             uop_out_valid,
  input  logic             issue_ready,
  input  logic             flush
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]        count;
  uop_t                    ent_uop [DEPTH];
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0]        ent_rs1_rdy;
  logic [DEPTH-1:0]        ent_rs2_rdy;
  logic [PHY_RF_DEPTH-1:0] phys_ready;

  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic                    do_issue;
  logic                    do_enq;
  logic                    enq_rs1_rdy;
  logic                    enq_rs2_rdy;
  logic [CNT_W-1:0]        wr_pos;
  logic [DEPTH-1:0]        woke1;
  logic [DEPTH-1:0]        woke2;
  logic [DEPTH:0]          valid_ext;
  logic [DEPTH:0]          rdy1_ext;
  logic [DEPTH:0]          rdy2_ext;
  uop_t                    n_uop [DEPTH];
  logic [DEPTH-1:0]        n_valid;
  logic [DEPTH-1:0]        n_rs1_rdy;
  logic [DEPTH-1:0]        n_rs2_rdy;
  logic [CNT_W-1:0]        n_count;
  logic [PHY_RF_DEPTH-1:0] n_phys_ready;

  // Oldest-first select: scanning downward leaves the lowest ready index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_rs1_rdy[i] && ent_rs2_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end else begin
        sel_found = sel_found;
        sel_idx   = sel_idx;
      end
    end
  end

  assign uop_out       = ent_uop[sel_idx];
  assign uop_out_valid = sel_found;
  assign full          = (count == CNT_W'(DEPTH));
  assign do_issue      = sel_found && issue_ready;
  assign do_enq        = uop_in_valid && !full;
  assign wr_pos        = count - CNT_W'(do_issue);

  // A source matching this cycle's writeback is captured ready at enqueue.
  assign enq_rs1_rdy = !uop_in.rs1_valid || phys_ready[uop_in.rs1]
                       || (cdb_valid && (cdb_tag == TAG_W'(uop_in.rs1)));
  assign enq_rs2_rdy = !uop_in.rs2_valid || phys_ready[uop_in.rs2]
                       || (cdb_valid && (cdb_tag == TAG_W'(uop_in.rs2)));

  // Wakeup of queued entries; registered, so it is seen by select one cycle later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke1[i] = ent_rs1_rdy[i] | (cdb_valid & ent_uop[i].rs1_valid
                                   & (TAG_W'(ent_uop[i].rs1) == cdb_tag));
      woke2[i] = ent_rs2_rdy[i] | (cdb_valid & ent_uop[i].rs2_valid
                                   & (TAG_W'(ent_uop[i].rs2) == cdb_tag));
    end
  end

  assign valid_ext = {1'b0, ent_valid};
  assign rdy1_ext  = {1'b0, woke1};
  assign rdy2_ext  = {1'b0, woke2};

  // Compaction on issue, then append the new uop behind the youngest survivor.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && (i >= int'(sel_idx))) begin
        n_valid[i]   = valid_ext[i+1];
        n_rs1_rdy[i] = rdy1_ext[i+1];
        n_rs2_rdy[i] = rdy2_ext[i+1];
        n_uop[i]     = ent_uop[(i+1) % DEPTH];
      end else begin
        n_valid[i]   = ent_valid[i];
        n_rs1_rdy[i] = woke1[i];
        n_rs2_rdy[i] = woke2[i];
        n_uop[i]     = ent_uop[i];
      end
      if (do_enq && (i == int'(wr_pos))) begin
        n_valid[i]   = 1'b1;
        n_rs1_rdy[i] = enq_rs1_rdy;
        n_rs2_rdy[i] = enq_rs2_rdy;
        n_uop[i]     = uop_in;
      end else begin
        n_valid[i]   = n_valid[i];
      end
    end
    n_count = count + CNT_W'(do_enq) - CNT_W'(do_issue);
  end

  // Register readiness: writeback sets, a new producer clears (clear wins).
  always_comb begin
    n_phys_ready = phys_ready;
    if (cdb_valid) begin
      n_phys_ready[cdb_tag] = 1'b1;
    end else begin
      n_phys_ready = n_phys_ready;
    end
    if (do_enq && uop_in.rd_valid) begin
      n_phys_ready[uop_in.rd] = 1'b0;
    end else begin
      n_phys_ready = n_phys_ready;
    end
  end

  // Control state; flush empties the queue but keeps register readiness.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      ent_valid   <= '0;
      ent_rs1_rdy <= '0;
      ent_rs2_rdy <= '0;
      phys_ready  <= '1;
    end else if (flush) begin
      count       <= '0;
      ent_valid   <= '0;
      ent_rs1_rdy <= '0;
      ent_rs2_rdy <= '0;
    end else begin
      count       <= n_count;
      ent_valid   <= n_valid;
      ent_rs1_rdy <= n_rs1_rdy;
      ent_rs2_rdy <= n_rs2_rdy;
      phys_ready  <= n_phys_ready;
    end
  end

  // Payload storage; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    ent_uop <= n_uop;
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_issue_queue;
  import iq_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, flush, uop_in_valid, cdb_valid, issue_ready;
  logic [6:0] cdb_tag;
  uop_t       uop_in, uop_out;
  logic       full, uop_out_valid;

  typedef struct {
    uop_t u;
    bit   r1;
    bit   r2;
  } ent_t;

  ent_t q[$];
  bit   pr[128];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  uop_t idle;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .PHY_RF_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .uop_in(uop_in), .uop_in_valid(uop_in_valid),
    .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .uop_out(uop_out),
    .uop_out_valid(uop_out_valid), .issue_ready(issue_ready), .flush(flush)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic uop_t mk(int id, int rs1, bit v1, int rs2, bit v2, int rd, bit vd);
    uop_t m;
    m.id = 16'(id); m.rs1 = 7'(rs1); m.rs1_valid = v1;
    m.rs2 = 7'(rs2); m.rs2_valid = v2; m.rd = 7'(rd); m.rd_valid = vd;
    return m;
  endfunction

  function automatic int model_sel();
    foreach (q[i]) if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  task automatic compare();
    int s;
    s = model_sel();
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("out_valid", 64'(uop_out_valid), 64'(s >= 0));
    if (s >= 0) chk("uop_out", 64'(uop_out), 64'(q[s].u));
  endtask

  task automatic model_update(bit r, bit fl, bit uv, uop_t u, bit cv, logic [6:0] ct, bit ir);
    int   s;
    bit   was_full;
    ent_t e;
    if (r) begin
      q.delete();
      foreach (pr[i]) pr[i] = 1'b1;
      return;
    end
    if (fl) begin
      q.delete();
      return;
    end
    s = model_sel();
    was_full = (q.size() == DEPTH);
    e.u  = u;
    e.r1 = !u.rs1_valid || pr[u.rs1] || (cv && ct == u.rs1);
    e.r2 = !u.rs2_valid || pr[u.rs2] || (cv && ct == u.rs2);
    if (s >= 0 && ir) q.delete(s);
    if (cv) begin
      foreach (q[i]) begin
        if (q[i].u.rs1_valid && q[i].u.rs1 == ct) q[i].r1 = 1'b1;
        if (q[i].u.rs2_valid && q[i].u.rs2 == ct) q[i].r2 = 1'b1;
      end
    end
    if (uv && !was_full) q.push_back(e);
    if (cv) pr[ct] = 1'b1;
    if (uv && !was_full && u.rd_valid) pr[u.rd] = 1'b0;
  endtask

  task automatic step(bit r, bit fl, bit uv, uop_t u, bit cv, logic [6:0] ct, bit ir);
    @(negedge clk);
    rst = r; flush = fl; uop_in_valid = uv; uop_in = u;
    cdb_valid = cv; cdb_tag = ct; issue_ready = ir;
    #1 compare();
    @(posedge clk);
    model_update(r, fl, uv, u, cv, ct, ir);
    #1;
  endtask

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; flush = 1'b0; uop_in_valid = 1'b0; uop_in = idle;
    cdb_valid = 1'b0; cdb_tag = 7'd0; issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    foreach (pr[i]) pr[i] = 1'b1;

    // Reset state
    step(1, 0, 0, idle, 0, 7'd0, 0);
    chk("rst_valid", 64'(uop_out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);

    // Single ready uop issues one cycle after enqueue; its rd becomes unready
    step(0, 0, 1, mk(1, 5, 1, 6, 1, 7, 1), 0, 7'd0, 1);
    chk("lat1_valid", 64'(uop_out_valid), 64'd1);
    chk("lat1_rd", 64'(uop_out.rd), 64'd7);
    step(0, 0, 0, idle, 0, 7'd0, 1);
    chk("lat1_empty", 64'(uop_out_valid), 64'd0);
    step(0, 0, 1, mk(2, 7, 1, 0, 0, 0, 0), 0, 7'd0, 1);
    chk("pr7_cleared", 64'(uop_out_valid), 64'd0);
    step(0, 0, 0, idle, 1, 7'd7, 0);
    chk("wake7_id", 64'(uop_out_valid ? uop_out.id : 16'hFFFF), 64'd2);
    step(0, 0, 0, idle, 0, 7'd0, 1);

    // Dependent uop held until writeback, issues the cycle after
    step(0, 0, 1, mk(3, 0, 0, 0, 0, 10, 1), 0, 7'd0, 0);
    chk("dep_a_id", 64'(uop_out.id), 64'd3);
    step(0, 0, 1, mk(4, 10, 1, 0, 0, 0, 0), 0, 7'd0, 1);
    chk("dep_b_held", 64'(uop_out_valid), 64'd0);
    step(0, 0, 0, idle, 1, 7'd10, 1);
    chk("dep_b_id", 64'(uop_out_valid ? uop_out.id : 16'hFFFF), 64'd4);
    step(0, 0, 0, idle, 0, 7'd0, 1);

    // Fill with unready uops; ninth is ignored
    step(0, 0, 1, mk(5, 0, 0, 0, 0, 20, 1), 0, 7'd0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 1, mk(6 + k, 20, 1, 0, 0, 0, 0), 0, 7'd0, 1);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_none_ready", 64'(uop_out_valid), 64'd0);
    step(0, 0, 1, mk(14, 0, 0, 0, 0, 0, 0), 0, 7'd0, 1);
    chk("ninth_full", 64'(full), 64'd1);
    chk("ninth_count", 64'(q.size()), 64'd8);

    // Flush with concurrent enqueue
    step(0, 1, 1, mk(15, 0, 0, 0, 0, 0, 0), 0, 7'd0, 1);
    chk("flush_full", 64'(full), 64'd0);
    chk("flush_valid", 64'(uop_out_valid), 64'd0);
    step(0, 0, 0, idle, 0, 7'd0, 1);

    // Younger ready entries bypass an unready oldest, which keeps slot 0
    step(0, 0, 1, mk(16, 0, 0, 0, 0, 30, 1), 0, 7'd0, 0);
    step(0, 0, 1, mk(17, 30, 1, 0, 0, 0, 0), 0, 7'd0, 1);
    step(0, 0, 1, mk(18, 0, 0, 0, 0, 0, 0), 0, 7'd0, 1);
    step(0, 0, 1, mk(19, 0, 0, 0, 0, 0, 0), 0, 7'd0, 0);
    chk("bypass_first", 64'(uop_out.id), 64'd18);
    step(0, 0, 0, idle, 0, 7'd0, 1);
    chk("bypass_second", 64'(uop_out.id), 64'd19);
    step(0, 0, 0, idle, 0, 7'd0, 1);
    chk("bypass_oldest_wait", 64'(uop_out_valid), 64'd0);
    step(0, 0, 0, idle, 1, 7'd30, 0);
    chk("bypass_oldest_id", 64'(uop_out_valid ? uop_out.id : 16'hFFFF), 64'd17);
    step(0, 0, 0, idle, 0, 7'd0, 1);

    // Same-cycle writeback captured at enqueue
    step(0, 0, 1, mk(20, 0, 0, 0, 0, 12, 1), 0, 7'd0, 0);
    step(0, 0, 0, idle, 0, 7'd0, 1);
    step(0, 0, 1, mk(21, 12, 1, 0, 0, 0, 0), 1, 7'd12, 0);
    chk("cdb_bypass_id", 64'(uop_out_valid ? uop_out.id : 16'hFFFF), 64'd21);
    step(0, 0, 0, idle, 0, 7'd0, 1);

    // Producer clear beats same-cycle writeback of the same register
    step(0, 0, 1, mk(22, 0, 0, 0, 0, 40, 1), 1, 7'd40, 1);
    step(0, 0, 1, mk(23, 40, 1, 0, 0, 0, 0), 0, 7'd0, 1);
    chk("clear_wins", 64'(uop_out_valid), 64'd0);
    step(0, 0, 0, idle, 1, 7'd40, 1);
    step(0, 0, 0, idle, 0, 7'd0, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      uop_t u;
      u = mk(100 + n, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
             $urandom_range(0, 15), 1'($urandom_range(0, 1)),
             $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0));
      step(($urandom_range(0, 799) == 0), ($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)), u, ($urandom_range(0, 2) == 0),
           7'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
